// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, bit-reverse helper, sample pair and read-FSM state types.
package fft_pkg;
  localparam int FFT_N = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_WIDTH = 16;
  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } sample_t;
  typedef enum logic {IDLE, READ} rd_state_t;
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx, input int log2n);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) r[i] = idx[FFT_LOG2N-1-i];
    return r >> (FFT_LOG2N - log2n);
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and one synchronous read port, no content reset.
module fft_reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural bin order.
// Define FFT_REORDER_MAG_EN to add o_do_mag (re^2+im^2) with one extra output register stage.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_di_en,
  input  logic signed [WIDTH-1:0] i_di_re,
  input  logic signed [WIDTH-1:0] i_di_im,
  output logic                    o_do_en,
  output logic signed [WIDTH-1:0] o_do_re,
  output logic signed [WIDTH-1:0] o_do_im,
  output logic [LOG2N-1:0]        o_do_idx,
  output logic                    o_do_last
`ifdef FFT_REORDER_MAG_EN
  , output logic [2*WIDTH-1:0]    o_do_mag
`endif
);
  rd_state_t r_state, w_state_nxt;
  logic [LOG2N-1:0] r_wcnt, r_rcnt, w_rcnt_nxt, r_ridx, r_idx;
  logic r_wbank, r_pbank, r_rbank, w_rbank_nxt, r_pending;
  logic w_done, w_start, w_wrap, w_take, w_ren, r_rv;
  logic [LOG2N:0] w_raddr;
  sample_t w_rdata;
  logic r_en, r_last;
  logic signed [WIDTH-1:0] r_re, r_im;
  fft_reorder_ram #(.DW($bits(sample_t)), .AW(LOG2N + 1)) u_ram (
    .i_clock (i_clock),
    .i_we    (i_di_en),
    .i_waddr ({r_wbank, bitrev(r_wcnt, LOG2N)}),
    .i_wdata ({i_di_re, i_di_im}),
    .i_re    (w_ren),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
  // Bin 0 is fetched from the IDLE state itself so a frame reaches the outputs two edges after completion.
  always_comb begin
    w_done      = i_di_en & (r_wcnt == LOG2N'(N-1));
    w_start     = (r_state == IDLE) & r_pending;
    w_wrap      = (r_state == READ) & (r_rcnt == LOG2N'(N-1));
    w_take      = w_start | (w_wrap & r_pending);
    w_ren       = w_start | (r_state == READ);
    w_raddr     = w_start ? {r_pbank, LOG2N'(0)} : {r_rbank, r_rcnt};
    w_state_nxt = w_start ? READ : (w_wrap & ~r_pending) ? IDLE : r_state;
    w_rcnt_nxt  = w_start ? LOG2N'(1) : (r_state == READ) ? r_rcnt + 1'b1 : r_rcnt;
    w_rbank_nxt = w_take ? r_pbank : r_rbank;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wcnt    <= '0;
      r_wbank   <= 1'b0;
      r_pbank   <= 1'b0;
      r_pending <= 1'b0;
      r_state   <= IDLE;
      r_rcnt    <= '0;
      r_rbank   <= 1'b0;
      r_rv      <= 1'b0;
      r_ridx    <= '0;
      r_en      <= 1'b0;
      r_re      <= '0;
      r_im      <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
    end else begin
      if (i_di_en) r_wcnt <= r_wcnt + 1'b1;
      if (w_done) begin
        r_wbank <= ~r_wbank;
        r_pbank <= r_wbank;
      end
      r_pending <= w_done | (r_pending & ~w_take);
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rbank   <= w_rbank_nxt;
      r_rv      <= w_ren;
      r_ridx    <= w_raddr[LOG2N-1:0];
      r_en      <= r_rv;
      r_re      <= r_rv ? w_rdata.re : '0;
      r_im      <= r_rv ? w_rdata.im : '0;
      r_idx     <= r_rv ? r_ridx : '0;
      r_last    <= r_rv & (r_ridx == LOG2N'(N-1));
    end
  end
`ifdef FFT_REORDER_MAG_EN
  logic signed [2*WIDTH-1:0] w_sq_re, w_sq_im;
  logic [2*WIDTH-1:0] r_mag;
  logic r2_en, r2_last;
  logic signed [WIDTH-1:0] r2_re, r2_im;
  logic [LOG2N-1:0] r2_idx;
  assign w_sq_re = r_re * r_re;
  assign w_sq_im = r_im * r_im;
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r2_en   <= 1'b0;
      r2_re   <= '0;
      r2_im   <= '0;
      r2_idx  <= '0;
      r2_last <= 1'b0;
      r_mag   <= '0;
    end else begin
      r2_en   <= r_en;
      r2_re   <= r_re;
      r2_im   <= r_im;
      r2_idx  <= r_idx;
      r2_last <= r_last;
      r_mag   <= $unsigned(w_sq_re) + $unsigned(w_sq_im);
    end
  end
  assign o_do_en   = r2_en;
  assign o_do_re   = r2_re;
  assign o_do_im   = r2_im;
  assign o_do_idx  = r2_idx;
  assign o_do_last = r2_last;
  assign o_do_mag  = r_mag;
`else
  assign o_do_en   = r_en;
  assign o_do_re   = r_re;
  assign o_do_im   = r_im;
  assign o_do_idx  = r_idx;
  assign o_do_last = r_last;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: table vectors, hand sequences and random frames against a frame-level reference model.
module tb_fft_bitrev_reorder;
  localparam int N = 64;
  localparam int W = 16;
`ifdef FFT_REORDER_MAG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    int     re;
    int     im;
    int     idx;
    int     last;
    longint mag;
    int     cyc;
  } out_t;
  typedef struct {
    int bin;
    int re;
    int im;
    int last;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, di_en = 1'b0;
  logic signed [W-1:0] di_re = '0, di_im = '0;
  logic do_en, do_last;
  logic signed [W-1:0] do_re, do_im;
  logic [5:0] do_idx;
  logic [2*W-1:0] do_mag;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  out_t cap[$], expq[$];
  int fr_re[N], fr_im[N];
  int wpos = 0, first_k = 0;
  bit fk_valid = 0;
  vec_t ramp_tab[6], imp_tab[5];

  always #5 clk = ~clk;

  fft_bitrev_reorder dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_di_en   (di_en),
    .i_di_re   (di_re),
    .i_di_im   (di_im),
    .o_do_en   (do_en),
    .o_do_re   (do_re),
    .o_do_im   (do_im),
    .o_do_idx  (do_idx),
    .o_do_last (do_last)
`ifdef FFT_REORDER_MAG_EN
    , .o_do_mag (do_mag)
`endif
  );
`ifndef FFT_REORDER_MAG_EN
  assign do_mag = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (do_en) cap.push_back('{int'(do_re), int'(do_im), int'(do_idx), int'(do_last), longint'(do_mag), cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < 6; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  task automatic check(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic put(input int re, input int im, input bit en);
    di_en = en;
    di_re = W'(re);
    di_im = W'(im);
    @(posedge clk);
    #1;
    di_en = 1'b0;
    if (en) begin
      fr_re[wpos] = re;
      fr_im[wpos] = im;
      wpos++;
      if (wpos == N) begin
        if (!fk_valid) begin
          first_k = cyc;
          fk_valid = 1;
        end
        for (int k = 0; k < N; k++) begin
          int p = brev(k);
          expq.push_back('{fr_re[p], fr_im[p], k, int'(k == N-1),
                           longint'(fr_re[p]) * fr_re[p] + longint'(fr_im[p]) * fr_im[p], 0});
        end
        wpos = 0;
      end
    end
  endtask

  task automatic clr();
    cap.delete();
    expq.delete();
    wpos = 0;
    fk_valid = 0;
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_en"}, do_en, 0);
    check({nm, "_re"}, do_re, 0);
    check({nm, "_im"}, do_im, 0);
    check({nm, "_idx"}, do_idx, 0);
    check({nm, "_last"}, do_last, 0);
`ifdef FFT_REORDER_MAG_EN
    check({nm, "_mag"}, do_mag, 0);
`endif
  endtask

  task automatic drain(input string nm, input bit contig);
    int gaps = 0;
    for (int i = 0; i < 600 && cap.size() < expq.size(); i++) @(posedge clk);
    repeat (LAT + 4) @(posedge clk);
    #1;
    check({nm, "_count"}, cap.size(), expq.size());
    for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
      check({nm, "_re"}, cap[i].re, expq[i].re);
      check({nm, "_im"}, cap[i].im, expq[i].im);
      check({nm, "_idx"}, cap[i].idx, expq[i].idx);
      check({nm, "_last"}, cap[i].last, expq[i].last);
`ifdef FFT_REORDER_MAG_EN
      check({nm, "_mag"}, cap[i].mag, expq[i].mag);
`endif
      if (i > 0 && (contig || i % N != 0) && cap[i].cyc != cap[i-1].cyc + 1) gaps++;
    end
    check({nm, "_gaps"}, gaps, 0);
    if (cap.size() > 0) check({nm, "_latency"}, cap[0].cyc - first_k, LAT);
  endtask

  task automatic chk_tab(input string nm, input vec_t t);
    if (cap.size() > t.bin) begin
      check({nm, "_tab_re"}, cap[t.bin].re, t.re);
      check({nm, "_tab_im"}, cap[t.bin].im, t.im);
      check({nm, "_tab_idx"}, cap[t.bin].idx, t.bin);
      check({nm, "_tab_last"}, cap[t.bin].last, t.last);
    end else check({nm, "_tab_missing"}, cap.size(), t.bin + 1);
  endtask

  initial begin
    ramp_tab = '{'{0, 0, 0, 0}, '{1, 1, -1, 0}, '{31, 31, -31, 0},
                 '{32, 32, -32, 0}, '{62, 62, -62, 0}, '{63, 63, -63, 1}};
    imp_tab  = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{32, 32767, 0, 0},
                 '{33, 0, 0, 0}, '{63, 0, 0, 1}};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    // ramp
    for (int i = 0; i < N; i++) put(brev(i), -brev(i), 1);
    drain("ramp", 1);
    foreach (ramp_tab[j]) chk_tab("ramp", ramp_tab[j]);
    clr();
    // impulse at bit-reversed input position 1
    for (int i = 0; i < N; i++) put(i == 1 ? 32767 : 0, 0, 1);
    drain("impulse", 1);
    foreach (imp_tab[j]) chk_tab("impulse", imp_tab[j]);
    clr();
    // gapped input 1,0,0
    for (int i = 0; i < N; i++) begin
      put(brev(i), -brev(i), 1);
      put(0, 0, 0);
      put(0, 0, 0);
    end
    drain("gapped", 0);
    foreach (ramp_tab[j]) chk_tab("gapped", ramp_tab[j]);
    clr();
    // four back-to-back frames
    for (int i = 0; i < 4 * N; i++) put($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
    drain("b2b", 1);
    clr();
    // reset during a partial input frame
    for (int i = 0; i < 30; i++) put($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_partial");
    rst_n = 1'b1;
    clr();
    repeat (80) @(posedge clk);
    #1;
    check("rst_partial_no_output", cap.size(), 0);
    // reset during output bin 10
    for (int i = 0; i < N; i++) put($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
    for (int i = 0; i < 300 && !(do_en && do_idx == 6'd10); i++) @(negedge clk);
    check("rst_out_bin10_seen", int'(do_en && do_idx == 6'd10), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_output");
    rst_n = 1'b1;
    clr();
    repeat (100) @(posedge clk);
    #1;
    check("rst_output_aborted", cap.size(), 0);
    for (int i = 0; i < N; i++) put($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
    drain("after_reset", 1);
    clr();
    // random data with random input gaps
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(0, 3) == 0) put(0, 0, 0);
        put($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1);
      end
    drain("random", 0);
    clr();
`ifdef FFT_REORDER_MAG_EN
    for (int i = 0; i < N; i++) put(3, -4, 1);
    drain("mag25", 1);
    if (cap.size() > 0) check("mag25_bin0", cap[0].mag, 25);
    clr();
    for (int i = 0; i < N; i++) put(-32768, -32768, 1);
    drain("magmax", 1);
    if (cap.size() > 5) check("magmax_bin5", cap[5].mag, 64'h8000_0000);
    clr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
